phase_map_builder: RTL and testbench

PHASE_MAP_BUILDER -- requirements
Module: phase_map_builder

---
 rtl/reflectarray_pkg.sv | 30 +++
 rtl/phase_quantizer.sv | 39 +++
 rtl/phase_map_builder.sv | 131 +++++++++++++
 tb/tb_phase_map_builder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reflectarray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reflectarray_pkg
// Description : Shared FSM encoding, array-size derivation and aperture mask
//               for the reflectarray phase-map builder.
// Revision    : 1.0 - initial release
// ============================================================================
package reflectarray_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  function automatic int calc_n(input int diameter, input int spacing);
    return diameter / spacing;
  endfunction

  // Element centre lies inside the circle, evaluated in doubled coordinates
  // so the half-cell offset stays an integer.
  function automatic logic in_aperture(input int row, input int col, input int n);
    int dx;
    int dy;
    dx = 2 * col - n + 1;
    dy = 2 * row - n + 1;
    return ((dx * dx + dy * dy) <= n * n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_quantizer.sv
`default_nettype none
// ============================================================================
// Module      : phase_quantizer
// Description : Adds the frame offset, rounds to the nearest quantized state
//               modulo one turn and masks elements outside the aperture.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_quantizer
  import reflectarray_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int QBITS   = 1,
  parameter int N       = 16,
  parameter int IDX_W   = 8
) (
  input  logic [PHASE_W-1:0] phase_i,
  input  logic [PHASE_W-1:0] offset_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [QBITS-1:0]   code_o
);

  localparam logic [PHASE_W-1:0] c_HALF_STEP = PHASE_W'(1) << (PHASE_W - QBITS - 1);

  logic [PHASE_W-1:0] w_sum;
  logic               w_inside;
  int                 w_row;
  int                 w_col;

  always_comb begin
    w_row    = int'(idx_i) / N;
    w_col    = int'(idx_i) % N;
    w_inside = in_aperture(w_row, w_col, N);
    // Carry out of the MSB is one full turn and is deliberately dropped.
    w_sum    = phase_i + offset_i + c_HALF_STEP;
    code_o   = w_inside ? w_sum[PHASE_W-1 -: QBITS] : '0;
  end

endmodule
`default_nettype wire

// File: rtl/phase_map_builder.sv
`default_nettype none
// ============================================================================
// Module      : phase_map_builder
// Description : Streams raster-ordered element phases into a double-buffered
//               quantized reflectarray map, publishing each completed frame.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_map_builder
  import reflectarray_pkg::*;
#(
  parameter  int ARRAY_DIAMETER  = 80,
  parameter  int ELEMENT_SPACING = 5,
  parameter  int PHASE_W         = 16,
  parameter  int QBITS           = 1,
  localparam int N               = calc_n(ARRAY_DIAMETER, ELEMENT_SPACING)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PHASE_W-1:0]   phase_offset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PHASE_W-1:0]   in_phase,
  output logic                 busy,
  output logic                 done,
  output logic [N*N*QBITS-1:0] map_flat
);

  localparam int NUM_EL = N * N;
  localparam int IDX_W  = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;
  localparam int MAP_W  = NUM_EL * QBITS;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_EL - 1);

  state_e             state_q,    state_d;
  logic [IDX_W-1:0]   cnt_q,      cnt_d;
  logic [PHASE_W-1:0] offset_q,   offset_d;
  logic               bank_sel_q, bank_sel_d;
  logic               done_q,     done_d;
  logic [MAP_W-1:0]   bank0_q,    bank0_d;
  logic [MAP_W-1:0]   bank1_q,    bank1_d;

  logic               w_accept;
  logic               w_last;
  logic [QBITS-1:0]   w_code;

  assign w_accept = in_valid && (state_q == ST_FILL);
  assign w_last   = w_accept && (cnt_q == c_LAST_IDX);

  phase_quantizer #(
    .PHASE_W (PHASE_W),
    .QBITS   (QBITS),
    .N       (N),
    .IDX_W   (IDX_W)
  ) u_quantizer (
    .phase_i  (in_phase),
    .offset_i (offset_q),
    .idx_i    (cnt_q),
    .code_o   (w_code)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    offset_d   = offset_q;
    bank_sel_d = bank_sel_q;
    done_d     = 1'b0;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_FILL;
          cnt_d    = '0;
          offset_d = phase_offset;
        end
      end
      ST_FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept) begin
          cnt_d = cnt_q + 1'b1;
          if (w_last) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            bank_sel_d = ~bank_sel_q;
            done_d     = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The back bank is whichever one map_flat is not currently showing.
  always_comb begin
    bank0_d = bank0_q;
    bank1_d = bank1_q;
    if (w_accept) begin
      if (bank_sel_q) begin
        bank0_d[int'(cnt_q) * QBITS +: QBITS] = w_code;
      end else begin
        bank1_d[int'(cnt_q) * QBITS +: QBITS] = w_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      offset_q   <= '0;
      bank_sel_q <= 1'b0;
      done_q     <= 1'b0;
      bank0_q    <= '0;
      bank1_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      offset_q   <= offset_d;
      bank_sel_q <= bank_sel_d;
      done_q     <= done_d;
      bank0_q    <= bank0_d;
      bank1_q    <= bank1_d;
    end
  end

  assign done     = done_q;
  assign map_flat = bank_sel_q ? bank1_q : bank0_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_map_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_map_builder
// Description : Scoreboard bench driving 1-bit and 2-bit map builders with
//               shared randomized frames against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_map_builder;

  localparam int N  = 16;
  localparam int NE = N * N;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [PW-1:0] phase_offset = '0;
  logic [PW-1:0] in_phase = '0;

  logic          rdy1, busy1, done1;
  logic          rdy2, busy2, done2;
  logic [255:0]  map1;
  logic [511:0]  map2;

  int            total = 0;
  int            bad = 0;
  int            ndone1 = 0;
  int            ndone2 = 0;
  int            nframes = 0;
  logic [511:0]  q1[$];
  logic [511:0]  q2[$];
  logic [511:0]  last1 = '0;
  logic [511:0]  last2 = '0;
  logic [PW-1:0] frame_ph[NE];

  always #5 clk = ~clk;

  phase_map_builder #(
    .ARRAY_DIAMETER (80), .ELEMENT_SPACING (5), .PHASE_W (PW), .QBITS (1)
  ) u_dut1 (
    .clk (clk), .rst_n (rst_n), .start (start), .phase_offset (phase_offset),
    .in_valid (in_valid), .in_ready (rdy1), .in_phase (in_phase),
    .busy (busy1), .done (done1), .map_flat (map1)
  );

  phase_map_builder #(
    .ARRAY_DIAMETER (80), .ELEMENT_SPACING (5), .PHASE_W (PW), .QBITS (2)
  ) u_dut2 (
    .clk (clk), .rst_n (rst_n), .start (start), .phase_offset (phase_offset),
    .in_valid (in_valid), .in_ready (rdy2), .in_phase (in_phase),
    .busy (busy2), .done (done2), .map_flat (map2)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // Reference: round each phase to the nearest of 2^qb states around the circle.
  function automatic logic [511:0] model_map(input int qb, input logic [PW-1:0] off);
    logic [511:0] m;
    m = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        int dx;
        int dy;
        int s;
        int code;
        dx = 2 * c - N + 1;
        dy = 2 * r - N + 1;
        code = 0;
        if (dx * dx + dy * dy <= N * N) begin
          s    = (int'(frame_ph[r * N + c]) + int'(off) + (1 << (PW - qb - 1))) % (1 << PW);
          code = s >> (PW - qb);
        end
        for (int b = 0; b < qb; b++) m[(r * N + c) * qb + b] = code[b];
      end
    end
    return m;
  endfunction

  task automatic check_reset_state();
    check("rst_map1", 512'(map1), '0);
    check("rst_map2", map2, '0);
    check("rst_ctrl", 512'({done1, busy1, rdy1, done2, busy2, rdy2}), '0);
  endtask

  task automatic run_frame(input logic [PW-1:0] off, input bit gaps,
                           input bit mid_start, input int abort_at);
    bit           acc;
    int           wait_cyc;
    logic [511:0] e1;
    logic [511:0] e2;
    e1 = model_map(1, off);
    e2 = model_map(2, off);
    start        = 1'b1;
    phase_offset = off;
    @(posedge clk); #1;
    start        = 1'b0;
    phase_offset = PW'($urandom);
    for (int i = 0; i < NE; i++) begin
      if (i == abort_at) begin
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
        return;
      end
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      if (mid_start && i == 128) start = 1'b1;
      in_valid = 1'b1;
      in_phase = frame_ph[i];
      wait_cyc = 0;
      do begin
        acc = rdy1;
        @(posedge clk); #1;
        wait_cyc++;
      end while (!acc && wait_cyc < 20);
      start = 1'b0;
      if (!acc) begin
        fail_now("handshake_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    q1.push_back(e1);
    q2.push_back(e2);
    nframes++;
  endtask

  task automatic fill_const(input logic [PW-1:0] v);
    for (int i = 0; i < NE; i++) frame_ph[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NE; i++) frame_ph[i] = PW'($urandom);
  endtask

  // Monitor: pops the expected map on every done and checks the front bank is
  // frozen while a fill is in progress.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last1 = '0;
        last2 = '0;
      end else begin
        if (done1) begin
          ndone1++;
          if (q1.size() == 0) fail_now("done1_unexpected", 1, 0);
          else begin
            last1 = q1.pop_front();
            check("map1_published", 512'(map1), last1);
          end
        end else if (q1.size() != 0) begin
          fail_now("done1_missing", 0, 1);
          void'(q1.pop_front());
        end
        if (done2) begin
          ndone2++;
          if (q2.size() == 0) fail_now("done2_unexpected", 1, 0);
          else begin
            last2 = q2.pop_front();
            check("map2_published", map2, last2);
          end
        end else if (q2.size() != 0) begin
          fail_now("done2_missing", 0, 1);
          void'(q2.pop_front());
        end
        if (busy1) check("map1_hold", 512'(map1), last1);
        if (busy2) check("map2_hold", map2, last2);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;

    fill_const(16'h8000);
    run_frame(16'h0000, 1'b0, 1'b0, -1);
    check("bit_r0_c7", 512'(map1[7]), 512'(1));
    check("bit_r0_c0_masked", 512'(map1[0]), 512'(0));

    fill_const(16'h0000);
    run_frame(16'h0000, 1'b0, 1'b0, -1);
    check("all_zero_frame", 512'(map1), '0);

    fill_rand();
    frame_ph[119] = 16'hC000;
    frame_ph[120] = 16'h3FFF;
    frame_ph[121] = 16'h4000;
    run_frame(16'h4000, 1'b0, 1'b0, -1);
    check("q1_off4000_C000", 512'(map1[119]), 512'(0));
    check("q1_off4000_3FFF", 512'(map1[120]), 512'(1));
    check("q1_off4000_4000", 512'(map1[121]), 512'(1));

    fill_rand();
    frame_ph[119] = 16'h3FFF;
    frame_ph[120] = 16'h4000;
    frame_ph[121] = 16'h6000;
    frame_ph[122] = 16'hF000;
    frame_ph[123] = 16'h1FFF;
    frame_ph[124] = 16'h2000;
    run_frame(16'h0000, 1'b0, 1'b0, -1);
    check("q1_off0_3FFF", 512'(map1[119]), 512'(0));
    check("q1_off0_4000", 512'(map1[120]), 512'(1));
    check("q2_6000", 512'(map2[242 +: 2]), 512'(2));
    check("q2_F000_wrap", 512'(map2[244 +: 2]), 512'(0));
    check("q2_1FFF", 512'(map2[246 +: 2]), 512'(0));
    check("q2_2000", 512'(map2[248 +: 2]), 512'(1));

    fill_rand();
    run_frame(PW'($urandom), 1'b1, 1'b1, -1);

    fill_rand();
    run_frame(PW'($urandom), 1'b1, 1'b0, 100);

    fill_rand();
    run_frame(PW'($urandom), 1'b1, 1'b0, -1);

    repeat (4) @(posedge clk);
    #1;
    check("done1_count", 512'(ndone1), 512'(nframes));
    check("done2_count", 512'(ndone2), 512'(nframes));
    check("q1_drained", 512'(q1.size()), '0);
    check("q2_drained", 512'(q2.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
